pong_game_controller: RTL

//  Game sequencer for Pong. It owns the ball position, direction and speed,
//  and runs serve/play/point phases. It detects wall and paddle collisions and

---
 rtl/pong_game_controller.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/pong_game_controller.sv
// Pong game sequencer: ball motion, wall/paddle collisions, scoring and serve/play/point phases.
// Optional PONG_SPEEDUP_EN: each paddle hit raises the x step by one, capped at MAX_DX.
//
// state  | meaning
// IDLE   | waiting for serve_btn; game_over shows whether the last game was won
// SERVE  | ball parked at the serve point for SERVE_TICKS ticks
// PLAY   | ball moves every tick; walls bounce, paddles return, misses score
// POINT  | ball parked for POINT_TICKS ticks, then next serve or game end
module pong_game_controller #(
    parameter int FRAME_W     = 640,
    parameter int FRAME_H     = 480,
    parameter int BALL_SIZE   = 9,
    parameter int PADDLE_W    = 12,
    parameter int PADDLE_H    = 60,
    parameter int P1_X        = 25,
    parameter int P2_X        = 615,
    parameter int BALL_X0     = 318,
    parameter int BALL_Y0     = 238,
    parameter int BALL_DX     = 4,
    parameter int BALL_DY     = 2,
    parameter int SERVE_TICKS = 30,
    parameter int POINT_TICKS = 60,
    parameter int WIN_SCORE   = 7
`ifdef PONG_SPEEDUP_EN
    ,
    parameter int MAX_DX      = 7
`endif
) (
    input  logic        CLOCK_25,
    input  logic        RESET_N,
    input  logic        tick,
    input  logic        serve_btn,
    input  logic [11:0] p1_y,
    input  logic [11:0] p2_y,
    output logic [11:0] ball_x,
    output logic [11:0] ball_y,
    output logic [3:0]  score_1,
    output logic [3:0]  score_2,
    output logic [1:0]  state,
    output logic        game_over
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_POINT = 2'd3
    } state_t;

    // 13-bit working width keeps every sum and paddle bound free of overflow
    localparam logic [12:0] X_MAX  = 13'(FRAME_W - 1 - BALL_SIZE);
    localparam logic [12:0] Y_MAX  = 13'(FRAME_H - 1 - BALL_SIZE);
    localparam logic [12:0] L_EDGE = 13'(P1_X + PADDLE_W);
    localparam logic [12:0] R_EDGE = 13'(P2_X);
    localparam logic [12:0] SIZE   = 13'(BALL_SIZE);
    localparam logic [12:0] PH     = 13'(PADDLE_H);
    localparam logic [12:0] DY     = 13'(BALL_DY);
    localparam logic [12:0] X0     = 13'(BALL_X0);
    localparam logic [12:0] Y0     = 13'(BALL_Y0);
    localparam logic [2:0]  DX0    = 3'(BALL_DX);
    localparam logic [3:0]  WIN    = 4'(WIN_SCORE);
    localparam logic [15:0] SERVE_LAST = 16'(SERVE_TICKS - 1);
    localparam logic [15:0] POINT_LAST = 16'(POINT_TICKS - 1);
`ifdef PONG_SPEEDUP_EN
    localparam logic [2:0]  DX_MAX = 3'(MAX_DX);
`endif

    state_t      state_q, state_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic [3:0]  s1_q, s1_d, s2_q, s2_d;
    logic        go_q, go_d;
    logic        left_q, left_d, top_q, top_d;
    logic [2:0]  dx_q, dx_d;
    logic [15:0] cnt_q, cnt_d;

    logic [12:0] xw, yw, dxw, p1w, p2w;
    logic        hit_l, hit_r, miss_l, miss_r;
    logic [2:0]  dx_hit;

    assign xw  = {1'b0, x_q};
    assign yw  = {1'b0, y_q};
    assign dxw = {10'd0, dx_q};
    assign p1w = {1'b0, p1_y};
    assign p2w = {1'b0, p2_y};

    assign hit_l  = left_q && (xw > L_EDGE) && (xw <= L_EDGE + dxw)
                    && (yw + SIZE >= p1w) && (yw <= p1w + PH);
    assign hit_r  = !left_q && (xw + SIZE < R_EDGE) && (xw + dxw + SIZE >= R_EDGE)
                    && (yw + SIZE >= p2w) && (yw <= p2w + PH);
    assign miss_l = left_q && !hit_l && (xw < 13'd1 + dxw);
    assign miss_r = !left_q && !hit_r && (xw + dxw > X_MAX);

`ifdef PONG_SPEEDUP_EN
    assign dx_hit = (dx_q >= DX_MAX) ? DX_MAX : dx_q + 3'd1;
`else
    assign dx_hit = dx_q;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        go_d    = go_q;
        left_d  = left_q;
        top_d   = top_q;
        dx_d    = dx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (serve_btn) begin
                    state_d = ST_SERVE;
                    s1_d    = 4'd0;
                    s2_d    = 4'd0;
                    go_d    = 1'b0;
                    cnt_d   = 16'd0;
                end
            end
            ST_SERVE: begin
                if (tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = ST_PLAY;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (top_q) begin
                        if (yw < 13'd1 + DY) begin
                            y_d   = 12'd1;
                            top_d = 1'b0;
                        end else begin
                            y_d = 12'(yw - DY);
                        end
                    end else if (yw + DY > Y_MAX) begin
                        y_d   = 12'(Y_MAX);
                        top_d = 1'b1;
                    end else begin
                        y_d = 12'(yw + DY);
                    end

                    if (hit_l) begin
                        x_d    = 12'(L_EDGE + 13'd1);
                        left_d = 1'b0;
                        dx_d   = dx_hit;
                    end else if (hit_r) begin
                        x_d    = 12'(R_EDGE - SIZE - 13'd1);
                        left_d = 1'b1;
                        dx_d   = dx_hit;
                    end else if (miss_l || miss_r) begin
                        // serve next toward the player who conceded
                        state_d = ST_POINT;
                        cnt_d   = 16'd0;
                        x_d     = 12'(X0);
                        y_d     = 12'(Y0);
                        left_d  = miss_l;
                        top_d   = 1'b0;
                        dx_d    = DX0;
                        if (miss_l && s2_q != 4'd15) s2_d = s2_q + 4'd1;
                        if (miss_r && s1_q != 4'd15) s1_d = s1_q + 4'd1;
                    end else if (left_q) begin
                        x_d = 12'(xw - dxw);
                    end else begin
                        x_d = 12'(xw + dxw);
                    end
                end
            end
            ST_POINT: begin
                if (tick) begin
                    top_d = 1'b0;
                    dx_d  = DX0;
                    if (cnt_q == POINT_LAST) begin
                        cnt_d = 16'd0;
                        if (s1_q == WIN || s2_q == WIN) begin
                            state_d = ST_IDLE;
                            go_d    = 1'b1;
                        end else begin
                            state_d = ST_SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            x_q     <= 12'(X0);
            y_q     <= 12'(Y0);
            s1_q    <= 4'd0;
            s2_q    <= 4'd0;
            go_q    <= 1'b0;
            left_q  <= 1'b0;
            top_q   <= 1'b0;
            dx_q    <= DX0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            go_q    <= go_d;
            left_q  <= left_d;
            top_q   <= top_d;
            dx_q    <= dx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign score_1   = s1_q;
    assign score_2   = s2_q;
    assign state     = state_q;
    assign game_over = go_q;

endmodule
